// File: rtl/cpu_pio_led_out_0.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pio_led_out_0
// Description : Avalon-MM output PIO for board LEDs. It provides a DATA register
//               with atomic set and clear aliases, and an optional per-bit blink
//               overlay driven by a programmable half-period counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_pio_led_out_0 #(
    parameter int          DATA_WIDTH  = 8,
    parameter int unsigned RESET_VALUE = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [31:0]           c_RESET_WORD = RESET_VALUE;
    localparam logic [DATA_WIDTH-1:0] c_RESET_DATA = c_RESET_WORD[DATA_WIDTH-1:0];

    localparam logic [1:0] c_ADDR_DATA   = 2'd0;
    localparam logic [1:0] c_ADDR_SET    = 2'd1;
    localparam logic [1:0] c_ADDR_CLEAR  = 2'd2;
    localparam logic [1:0] c_ADDR_BLINK  = 2'd3;

    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_blink_mask;
    logic [15:0]           r_blink_period;
    logic [15:0]           r_blink_cnt;
    logic                  r_blink_phase;
    logic [31:0]           r_readdata;

    logic                  w_wr;
    logic                  w_blink_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [31:0]           w_rd_mux;

    assign w_wr       = chipselect & ~write_n;
    assign w_blink_wr = w_wr && (address == c_ADDR_BLINK);
    assign w_wdata    = writedata[DATA_WIDTH-1:0];

    // Data register: direct load, set-bits and clear-bits aliases
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= c_RESET_DATA;
        end else if (w_wr) begin
            case (address)
                c_ADDR_DATA:  r_data <= w_wdata;
                c_ADDR_SET:   r_data <= r_data | w_wdata;
                c_ADDR_CLEAR: r_data <= r_data & ~w_wdata;
                default:      r_data <= r_data;
            endcase
        end
    end

    // Blink configuration is loaded only by a write to the BLINK address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_mask   <= '0;
            r_blink_period <= '0;
        end else if (w_blink_wr) begin
            r_blink_mask   <= w_wdata;
            r_blink_period <= writedata[31:16];
        end
    end

    // Half-period counter; a BLINK write restarts it at phase 0, period 0 parks it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_blink_wr || (r_blink_period == 16'd0)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == (r_blink_period - 16'd1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 16'd1;
        end
    end

    // Read mux; unused bits stay zero
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_ADDR_DATA: w_rd_mux[DATA_WIDTH-1:0] = r_data;
            c_ADDR_BLINK: begin
                w_rd_mux[31:16]          = r_blink_period;
                w_rd_mux[DATA_WIDTH-1:0] = r_blink_mask;
            end
            default: w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_data ^ (r_blink_mask & {DATA_WIDTH{r_blink_phase}});

endmodule
`default_nettype wire

// File: tb/tb_cpu_pio_led_out_0.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pio_led_out_0
// Description : Self-checking bench for cpu_pio_led_out_0: an abstract model
//               (blink phase derived from elapsed cycles) compared every
//               cycle, plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pio_led_out_0;

    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    cpu_pio_led_out_0 #(.DATA_WIDTH(DW), .RESET_VALUE(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: LED pattern, blink config, cycles elapsed since blink (re)start
    logic [DW-1:0] m_data   = '0;
    logic [DW-1:0] m_mask   = '0;
    logic [15:0]   m_period = '0;
    int            m_t      = 0;
    logic [31:0]   m_rd     = '0;

    function automatic logic [DW-1:0] m_out();
        bit ph;
        ph = (m_period != 0) && (((m_t / int'(m_period)) % 2) == 1);
        return m_data ^ (ph ? m_mask : '0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data = '0; m_mask = '0; m_period = '0; m_t = 0; m_rd = '0;
        end else begin
            case (address)
                2'd0:    m_rd = {24'h0, m_data};
                2'd3:    m_rd = {m_period, 8'h0, m_mask};
                default: m_rd = '0;
            endcase
            if (chipselect && !write_n && address == 2'd3) begin
                m_mask   = writedata[DW-1:0];
                m_period = writedata[31:16];
                m_t      = 0;
            end else if (m_period != 0) begin
                m_t = m_t + 1;
            end else begin
                m_t = 0;
            end
            if (chipselect && !write_n) begin
                case (address)
                    2'd0:    m_data = writedata[DW-1:0];
                    2'd1:    m_data = m_data | writedata[DW-1:0];
                    2'd2:    m_data = m_data & ~writedata[DW-1:0];
                    default: m_data = m_data;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out_port", {24'h0, out_port}, {24'h0, m_out()});
            chk("model_readdata", readdata, m_rd);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cyc(1);
        chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        address = a;
        cyc(1);
        chk(name, readdata, exp);
    endtask

    task automatic out_chk(input string name, input logic [7:0] exp);
        chk(name, {24'h0, out_port}, {24'h0, exp});
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'h0;
        cyc(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        out_chk("reset_out", 8'h00);
        chk("reset_rd", readdata, 32'h0);

        // Plain data write and readback
        wr(2'd0, 32'h0000_00A5);
        out_chk("data_a5", 8'hA5);
        rd_chk("rd_a5", 2'd0, 32'h0000_00A5);

        // Set / clear aliases
        wr(2'd0, 32'h0000_000F);
        wr(2'd1, 32'h0000_0030);
        out_chk("outset", 8'h3F);
        wr(2'd2, 32'h0000_0003);
        out_chk("outclear", 8'h3C);
        rd_chk("rd_addr1", 2'd1, 32'h0);
        rd_chk("rd_addr2", 2'd2, 32'h0);

        // Blink period 4, mask 0x81
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0004_0081);
        for (int i = 0; i < 16; i++) begin
            out_chk("blink4", (((i / 4) % 2) == 1) ? 8'h81 : 8'h00);
            cyc(1);
        end
        rd_chk("rd_blink", 2'd3, 32'h0004_0081);

        // OUTSET during blink, then BLINK rewrite mid-period
        wr(2'd1, 32'h0000_0001);
        out_chk("set_in_blink_p0", 8'h01);
        cyc(2);
        out_chk("set_in_blink_p1", 8'h80);
        cyc(1);
        wr(2'd3, 32'h0004_0081);
        out_chk("rewrite_p0", 8'h01);
        cyc(3);
        out_chk("rewrite_hold", 8'h01);
        cyc(1);
        out_chk("rewrite_toggle", 8'h80);

        // Non-accepted bus cycles on each address change nothing
        for (int a = 0; a < 4; a++) begin
            address = 2'(a); writedata = 32'hFFFF_FFFF;
            chipselect = 1'b0; write_n = 1'b0;
            cyc(1);
            chipselect = 1'b1; write_n = 1'b1;
            cyc(1);
        end
        chipselect = 1'b0; writedata = 32'h0;
        rd_chk("rd_after_ignored", 2'd0, 32'h0000_0001);
        rd_chk("rd_blink_after_ignored", 2'd3, 32'h0004_0081);

        // Period 0 disables blink; out follows data
        wr(2'd3, 32'h0000_00FF);
        cyc(5);
        out_chk("period0", 8'h01);
        wr(2'd0, 32'hFFFF_FF5A);
        out_chk("data_upper_ignored", 8'h5A);
        rd_chk("rd_period0", 2'd3, 32'h0000_00FF);

        // Period 1 toggles every cycle
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0001_000F);
        out_chk("period1_a", 8'h00);
        cyc(1);
        out_chk("period1_b", 8'h0F);
        cyc(1);
        out_chk("period1_c", 8'h00);

        // Asynchronous reset mid-blink
        wr(2'd3, 32'h0002_0003);
        address = 2'd3;
        cyc(2);
        out_chk("pre_reset_blink", 8'h03);
        #2;
        reset = 1'b1;
        #1;
        out_chk("async_reset_out", 8'h00);
        chk("async_reset_rd", readdata, 32'h0);
        cyc(1);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            out_chk("post_reset_static", 8'h00);
        end
        rd_chk("post_reset_rd3", 2'd3, 32'h0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
